// File: rtl/mc_sequencer.sv
// mc_sequencer: multicycle IF/ID/EX/MEM/WB phase sequencer for the 16-bit CPU.
// Steps each instruction by class, waits on mem_ready, traps HLT/illegal, counts retirements.
module mc_sequencer #(
    parameter int                  OPCODE_W = 4,
    parameter int                  FUNC_W   = 6,
    parameter int                  CNT_W    = 16,
    parameter logic [OPCODE_W-1:0] RTYPE_OP = OPCODE_W'(4'hF),
    parameter logic [FUNC_W-1:0]   HLT_FUNC = FUNC_W'(29),
    parameter logic [FUNC_W-1:0]   JPR_FUNC = FUNC_W'(25),
    parameter logic [FUNC_W-1:0]   JRL_FUNC = FUNC_W'(26)
) (
    input  logic                clk,
    input  logic                Reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNC_W-1:0]   func_code,
    input  logic                mem_ready,
    output logic [2:0]          state,
    output logic                inst_done,
    output logic                halted,
    output logic                illegal,
    output logic [CNT_W-1:0]    num_inst
);

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_IF    = 3'd1,
        S_ID    = 3'd2,
        S_EX    = 3'd3,
        S_MEM   = 3'd4,
        S_WB    = 3'd5,
        S_HALT  = 3'd6,
        S_BAD   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CL_BRANCH,
        CL_IMM,
        CL_LWD,
        CL_SWD,
        CL_JUMP,
        CL_ALU,
        CL_HLT,
        CL_ILL
    } class_t;

    localparam logic [OPCODE_W-1:0] OP_BR_MAX  = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_IMM_MAX = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_LWD     = OPCODE_W'(7);
    localparam logic [OPCODE_W-1:0] OP_SWD     = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_JMP     = OPCODE_W'(9);
    localparam logic [OPCODE_W-1:0] OP_JAL     = OPCODE_W'(10);

    state_t              r_state;
    state_t              w_next;
    class_t              w_class;
    logic [OPCODE_W-1:0] r_ir_op;
    logic [FUNC_W-1:0]   r_ir_func;
    logic                r_illegal;
    logic                r_halted;
    logic [CNT_W-1:0]    r_num_inst;
    logic                w_inst_done;
    logic                w_set_illegal;

    // Class decode looks only at the latched fields, never at the live bus.
    always_comb begin
        w_class = CL_ILL;
        if (r_ir_op == RTYPE_OP) begin
            if (r_ir_func == HLT_FUNC)
                w_class = CL_HLT;
            else if (r_ir_func == JPR_FUNC || r_ir_func == JRL_FUNC)
                w_class = CL_JUMP;
            else
                w_class = CL_ALU;
        end else if (r_ir_op <= OP_BR_MAX) begin
            w_class = CL_BRANCH;
        end else if (r_ir_op <= OP_IMM_MAX) begin
            w_class = CL_IMM;
        end else if (r_ir_op == OP_LWD) begin
            w_class = CL_LWD;
        end else if (r_ir_op == OP_SWD) begin
            w_class = CL_SWD;
        end else if (r_ir_op == OP_JMP || r_ir_op == OP_JAL) begin
            w_class = CL_JUMP;
        end
    end

    // NOTE: every combinational output gets a default before the case so no path can infer a latch.
    always_comb begin
        w_next        = r_state;
        w_inst_done   = 1'b0;
        w_set_illegal = 1'b0;
        case (r_state)
            S_RESET: w_next = S_IF;
            S_IF: begin
                if (mem_ready)
                    w_next = S_ID;
            end
            S_ID: begin
                case (w_class)
                    CL_JUMP: begin
                        w_next      = S_IF;
                        w_inst_done = 1'b1;
                    end
                    CL_HLT: begin
                        w_next      = S_HALT;
                        w_inst_done = 1'b1;
                    end
                    CL_ILL: begin
                        w_next        = S_IF;
                        w_set_illegal = 1'b1;
                    end
                    default: w_next = S_EX;
                endcase
            end
            S_EX: begin
                case (w_class)
                    CL_BRANCH: begin
                        w_next      = S_IF;
                        w_inst_done = 1'b1;
                    end
                    CL_IMM, CL_ALU: w_next = S_WB;
                    CL_LWD, CL_SWD: w_next = S_MEM;
                    default:        w_next = S_IF;
                endcase
            end
            S_MEM: begin
                if (w_class == CL_LWD) begin
                    if (mem_ready)
                        w_next = S_WB;
                end else if (w_class == CL_SWD) begin
                    if (mem_ready) begin
                        w_next      = S_IF;
                        w_inst_done = 1'b1;
                    end
                end else begin
                    w_next = S_IF;
                end
            end
            S_WB: begin
                w_next      = S_IF;
                w_inst_done = 1'b1;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_IF;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= S_RESET;
            r_ir_op    <= '0;
            r_ir_func  <= '0;
            r_illegal  <= 1'b0;
            r_halted   <= 1'b0;
            r_num_inst <= '0;
        end else begin
            r_state  <= w_next;
            r_halted <= (w_next == S_HALT);
            if (r_state == S_IF && mem_ready) begin
                r_ir_op   <= opcode;
                r_ir_func <= func_code;
            end
            if (w_set_illegal)
                r_illegal <= 1'b1;
            if (w_inst_done)
                r_num_inst <= r_num_inst + CNT_W'(1);
        end
    end

    assign state     = r_state;
    assign inst_done = w_inst_done;
    assign halted    = r_halted;
    assign illegal   = r_illegal;
    assign num_inst  = r_num_inst;

endmodule

// File: tb/tb_mc_sequencer.sv
// Scoreboard bench for mc_sequencer: the driver queues expected retirements,
// a negedge monitor pops and checks them whenever inst_done is seen.
module tb_mc_sequencer;

    logic        clk = 1'b0;
    logic        Reset;
    logic [3:0]  opcode;
    logic [5:0]  func_code;
    logic        mem_ready;
    logic [2:0]  state, state4;
    logic        inst_done, inst_done4;
    logic        halted, halted4;
    logic        illegal, illegal4;
    logic [15:0] num_inst;
    logic [3:0]  num_inst4;

    mc_sequencer u_dut (
        .clk       (clk),
        .Reset     (Reset),
        .opcode    (opcode),
        .func_code (func_code),
        .mem_ready (mem_ready),
        .state     (state),
        .inst_done (inst_done),
        .halted    (halted),
        .illegal   (illegal),
        .num_inst  (num_inst)
    );

    // Narrow-counter instance sharing the same stimulus, used for the wrap case.
    mc_sequencer #(.CNT_W(4)) u_dut4 (
        .clk       (clk),
        .Reset     (Reset),
        .opcode    (opcode),
        .func_code (func_code),
        .mem_ready (mem_ready),
        .state     (state4),
        .inst_done (inst_done4),
        .halted    (halted4),
        .illegal   (illegal4),
        .num_inst  (num_inst4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   n_done  = 0;
    int   exp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every retirement must match the next queued expectation.
    always @(negedge clk) begin
        if (Reset === 1'b0 && inst_done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_inst_done: cycle %0d state %0d, no retirement queued", cyc, state);
            end else begin
                mon_e = sb_q.pop_front();
                check("retire_cycle", cyc, mon_e.cyc);
                check("num_inst_at_retire", {16'd0, num_inst}, mon_e.cnt % 65536);
                check("num_inst_w4_at_retire", {28'd0, num_inst4}, mon_e.cnt % 16);
                check("inst_done_w4", {31'd0, inst_done4}, 1);
                n_done++;
            end
        end
    end

    task automatic wait_if();
        int n = 0;
        while (state !== 3'd1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_IF", {29'd0, state}, 1);
    endtask

    // Issue one instruction: ifw/memw wait cycles in IF/MEM, lat is the no-wait latency.
    task automatic run_inst(input logic [3:0] op, input logic [5:0] fn, input int lat,
                            input int ifw, input int memw, input bit retires, input bit has_mem);
        int t0;
        int total;
        wait_if();
        t0    = cyc;
        total = lat + ifw + memw;
        if (retires) begin
            sb_q.push_back('{t0 + total - 1, exp_cnt});
            exp_cnt++;
        end
        for (int c = 0; c < total; c++) begin
            if (c < ifw) begin
                opcode    = 4'hC;
                func_code = 6'd29;
                mem_ready = 1'b0;
                check("if_wait_state", {29'd0, state}, 1);
            end else if (c == ifw) begin
                opcode    = op;
                func_code = fn;
                mem_ready = 1'b1;
            end else begin
                opcode    = 4'hC;
                func_code = 6'd29;
                if (has_mem && c >= ifw + 3 && c < ifw + 3 + memw) begin
                    mem_ready = 1'b0;
                    check("mem_wait_state", {29'd0, state}, 4);
                end else begin
                    mem_ready = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        Reset     = 1'b1;
        mem_ready = 1'b1;
        opcode    = 4'h0;
        func_code = 6'd0;
        #1;
        check("rst_state", {29'd0, state}, 0);
        check("rst_num_inst", {16'd0, num_inst}, 0);
        check("rst_illegal", {31'd0, illegal}, 0);
        check("rst_halted", {31'd0, halted}, 0);
        check("rst_inst_done", {31'd0, inst_done}, 0);
        repeat (2) @(posedge clk);
        #1;
        Reset = 1'b0;
        check("held_reset_state", {29'd0, state}, 0);
        @(posedge clk);
        #1;
        check("first_edge_state", {29'd0, state}, 1);

        // Back-to-back branch, immediate, LWD, SWD, jump.
        run_inst(4'h0, 6'd0, 3, 0, 0, 1, 0);
        run_inst(4'h4, 6'd0, 4, 0, 0, 1, 0);
        run_inst(4'h7, 6'd0, 5, 0, 0, 1, 1);
        run_inst(4'h8, 6'd0, 4, 0, 0, 1, 1);
        run_inst(4'h9, 6'd0, 2, 0, 0, 1, 0);
        wait_if();
        check("count_after_five", {16'd0, num_inst}, 5);
        check("done_pulses_five", n_done, 5);

        // Remaining classes: branch 3, imm 6, jump 10, ALU, JPR, JRL.
        run_inst(4'h3, 6'd0,  3, 0, 0, 1, 0);
        run_inst(4'h6, 6'd0,  4, 0, 0, 1, 0);
        run_inst(4'hA, 6'd0,  2, 0, 0, 1, 0);
        run_inst(4'hF, 6'd7,  4, 0, 0, 1, 0);
        run_inst(4'hF, 6'd25, 2, 0, 0, 1, 0);
        run_inst(4'hF, 6'd26, 2, 0, 0, 1, 0);
        wait_if();
        check("count_after_eleven", {16'd0, num_inst}, 11);

        // Asynchronous reset in the middle of an ALU instruction's EX phase.
        opcode    = 4'hF;
        func_code = 6'd0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("alu_in_ex", {29'd0, state}, 3);
        #2;
        Reset = 1'b1;
        #1;
        check("midex_rst_state", {29'd0, state}, 0);
        check("midex_rst_num_inst", {16'd0, num_inst}, 0);
        check("midex_rst_inst_done", {31'd0, inst_done}, 0);
        exp_cnt = 0;
        @(posedge clk);
        #1;
        Reset = 1'b0;
        check("midex_held_state", {29'd0, state}, 0);
        @(posedge clk);
        #1;
        check("midex_release_state", {29'd0, state}, 1);

        // LWD with 2 IF waits and 3 MEM waits: 10 cycles, one retirement.
        run_inst(4'h7, 6'd0, 5, 2, 3, 1, 1);
        wait_if();
        check("lwd_wait_count", {16'd0, num_inst}, 1);
        // SWD with 1 IF wait and 2 MEM waits.
        run_inst(4'h8, 6'd0, 4, 1, 2, 1, 1);

        // Illegal opcodes do not retire; the flag is sticky.
        run_inst(4'hB, 6'd0, 2, 0, 0, 0, 0);
        wait_if();
        check("illegal_set", {31'd0, illegal}, 1);
        check("illegal_no_count", {16'd0, num_inst}, 2);
        run_inst(4'h9, 6'd0, 2, 0, 0, 1, 0);
        run_inst(4'hD, 6'd0, 2, 0, 0, 0, 0);
        wait_if();
        check("illegal_sticky", {31'd0, illegal}, 1);
        check("count_after_illegal", {16'd0, num_inst}, 3);

        // Sixteen jumps: the 4-bit counter passes 15 -> 0.
        for (int i = 0; i < 16; i++)
            run_inst(4'h9, 6'd0, 2, 0, 0, 1, 0);
        wait_if();
        check("count_after_jumps", {16'd0, num_inst}, 19);
        check("count_w4_wrapped", {28'd0, num_inst4}, 3);

        // HLT retires in ID then parks in HALT.
        run_inst(4'hF, 6'd29, 2, 0, 0, 1, 0);
        check("halt_state", {29'd0, state}, 6);
        check("halt_flag", {31'd0, halted}, 1);
        check("halt_count", {16'd0, num_inst}, 20);
        for (int i = 0; i < 6; i++) begin
            opcode    = (i % 2 == 0) ? 4'h9 : 4'h7;
            func_code = 6'd0;
            mem_ready = (i % 2 == 0) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            check("halt_absorbing_state", {29'd0, state}, 6);
            check("halt_frozen_count", {16'd0, num_inst}, 20);
        end
        check("halt_illegal_kept", {31'd0, illegal}, 1);
        check("w4_state_halt", {29'd0, state4}, 6);
        check("w4_halted", {31'd0, halted4}, 1);
        check("w4_illegal", {31'd0, illegal4}, 1);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
